sa_cache_refill: RTL and testbench

Memory-side miss handler sitting directly downstream of `sa_cache`. It accepts one line-miss request at a time, optionally writes the dirty victim line back word-by-word, and fetches the missing line word-by-word from main memory. It then returns the assembled line to the cache in a single-cycle fill pulse. It is the only path between `sa_cache` and the memory port.

---
 rtl/sa_cache_pkg.sv | 15 +
 rtl/sa_cache_refill_if.sv | 36 +++
 rtl/sa_cache_refill.sv | 78 +++++++
 tb/tb_sa_cache_refill.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_cache_pkg.sv
// sa_cache_pkg: line geometry, refill FSM states and line alignment shared with sa_cache
package sa_cache_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WORDS  = 4;
    localparam int LINE_W = DATA_W * WORDS;
    localparam int OFF_W  = $clog2(WORDS * DATA_W / 8);
    localparam int CNT_W  = $clog2(WORDS);

    typedef enum logic [2:0] {IDLE, WB, RD_REQ, RD_WAIT, FILL} refill_state_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/sa_cache_refill_if.sv
// sa_cache_refill_if: miss, memory and fill channels around the refill engine
interface sa_cache_refill_if;
    import sa_cache_pkg::*;
    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic [LINE_W-1:0] victim_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              fill_valid;
    logic [ADDR_W-1:0] fill_addr;
    logic [LINE_W-1:0] fill_data;

    // refill engine view: consumes misses, masters memory, produces fills
    modport master (
        input  miss_valid, miss_addr, miss_dirty, victim_addr, victim_data,
               mem_req_ready, mem_rvalid, mem_rdata,
        output miss_ready, mem_req_valid, mem_we, mem_addr, mem_wdata,
               fill_valid, fill_addr, fill_data
    );

    // cache plus memory view
    modport slave (
        output miss_valid, miss_addr, miss_dirty, victim_addr, victim_data,
               mem_req_ready, mem_rvalid, mem_rdata,
        input  miss_ready, mem_req_valid, mem_we, mem_addr, mem_wdata,
               fill_valid, fill_addr, fill_data
    );
endinterface

// File: rtl/sa_cache_refill.sv
// sa_cache_refill: one miss at a time, optional victim writeback, word-by-word line fetch, single-cycle fill
module sa_cache_refill
    import sa_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sa_cache_refill_if.master bus
);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [CNT_W-1:0]  LAST       = CNT_W'(WORDS - 1);

    refill_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] miss_base_q, victim_base_q, word_off;
    logic [LINE_W-1:0] victim_q, buf_q;
    logic              accept, req_hs, last_word;

    assign accept    = bus.miss_valid & bus.miss_ready;
    assign req_hs    = bus.mem_req_valid & bus.mem_req_ready;
    assign last_word = (cnt_q == LAST);
    assign word_off  = ADDR_W'(cnt_q) * WORD_BYTES;

    // every output is decoded from registered state only, and forced to zero outside its state
    assign bus.miss_ready    = (state_q == IDLE);
    assign bus.mem_req_valid = (state_q == WB) || (state_q == RD_REQ);
    assign bus.mem_we        = (state_q == WB);
    assign bus.mem_addr      = (state_q == WB) ? victim_base_q + word_off :
                               (state_q == RD_REQ) ? miss_base_q + word_off : '0;
    assign bus.mem_wdata     = (state_q == WB) ? victim_q[DATA_W*cnt_q +: DATA_W] : '0;
    assign bus.fill_valid    = (state_q == FILL);
    assign bus.fill_addr     = (state_q == FILL) ? miss_base_q : '0;
    assign bus.fill_data     = (state_q == FILL) ? buf_q : '0;

    // next state and word counter; only one memory transaction is ever outstanding
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = bus.miss_dirty ? WB : RD_REQ;
                cnt_d   = '0;
            end
            WB: if (req_hs) begin
                state_d = last_word ? RD_REQ : WB;
                cnt_d   = last_word ? '0 : cnt_q + 1'b1;
            end
            RD_REQ: if (req_hs) state_d = RD_WAIT;
            RD_WAIT: if (bus.mem_rvalid) begin
                state_d = last_word ? FILL : RD_REQ;
                cnt_d   = last_word ? cnt_q : cnt_q + 1'b1;
            end
            FILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, counter, request latch at acceptance and read buffer assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            miss_base_q   <= '0;
            victim_base_q <= '0;
            victim_q      <= '0;
            buf_q         <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                miss_base_q   <= line_align(bus.miss_addr);
                victim_base_q <= line_align(bus.victim_addr);
                victim_q      <= bus.victim_data;
            end
            if (state_q == RD_WAIT && bus.mem_rvalid)
                buf_q[DATA_W*cnt_q +: DATA_W] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_sa_cache_refill.sv
// tb_sa_cache_refill: scoreboard bench driving misses against a word memory model
module tb_sa_cache_refill;
    import sa_cache_pkg::*;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] addr; logic [LINE_W-1:0] data; } fill_t;

    logic clk;
    logic rst;
    sa_cache_refill_if bif ();
    sa_cache_refill dut (.clk(clk), .rst(rst), .bus(bif));

    req_t        exp_req_q[$];
    fill_t       exp_fill_q[$];
    int          rd_cyc_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    int          errors = 0, checks = 0, cyc = 0, fill_cnt = 0, fill_cyc = 0, acc_cyc = 0, stall_left = 0;
    logic [31:0] stall_addr = 0, pend_addr = 0, p_addr = 0, p_wdata = 0;
    logic        p_we = 0, prev_stall = 0, rd_pend = 0, spur = 0, rnd_ready = 0;
    logic [LINE_W-1:0] last_fill = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // one cycle: monitor outputs at negedge, play memory, drive inputs for the next edge
    task automatic step();
        req_t e;
        fill_t f;
        logic tgt, stall;
        @(negedge clk);
        cyc++;
        if (prev_stall) begin
            checks++;
            if (bif.mem_req_valid !== 1'b1 || bif.mem_we !== p_we || bif.mem_addr !== p_addr || bif.mem_wdata !== p_wdata) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b we=%b addr=%h wdata=%h want v=1 we=%b addr=%h wdata=%h",
                         cyc, bif.mem_req_valid, bif.mem_we, bif.mem_addr, bif.mem_wdata, p_we, p_addr, p_wdata);
            end
        end
        if (bif.fill_valid === 1'b1) begin
            fill_cnt++;
            fill_cyc = cyc;
            last_fill = bif.fill_data;
            checks++;
            if (exp_fill_q.size() == 0) begin
                errors++;
                $display("FAIL fill_unexpected cyc=%0d got addr=%h want no fill", cyc, bif.fill_addr);
            end else begin
                f = exp_fill_q.pop_front();
                if (bif.fill_addr !== f.addr || bif.fill_data !== f.data) begin
                    errors++;
                    $display("FAIL fill cyc=%0d got addr=%h data=%h want addr=%h data=%h",
                             cyc, bif.fill_addr, bif.fill_data, f.addr, f.data);
                end
            end
        end
        bif.mem_rvalid = rd_pend | spur;
        bif.mem_rdata  = rd_pend ? mem_rd(pend_addr) : 32'hDEAD_BEEF;
        rd_pend = 1'b0;
        spur    = 1'b0;
        tgt   = bif.mem_req_valid && bif.mem_we && stall_left > 0 && bif.mem_addr == stall_addr;
        stall = tgt || (bif.mem_req_valid && rnd_ready && $urandom_range(3) == 0);
        if (tgt) stall_left--;
        bif.mem_req_ready = !stall;
        prev_stall = stall;
        p_we = bif.mem_we;
        p_addr = bif.mem_addr;
        p_wdata = bif.mem_wdata;
        if (bif.mem_req_valid === 1'b1 && !stall) begin
            checks++;
            if (exp_req_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected cyc=%0d got we=%b addr=%h want no request", cyc, bif.mem_we, bif.mem_addr);
            end else begin
                e = exp_req_q.pop_front();
                if (bif.mem_we !== e.we || bif.mem_addr !== e.addr || (e.we && bif.mem_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL req cyc=%0d got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                             cyc, bif.mem_we, bif.mem_addr, bif.mem_wdata, e.we, e.addr, e.wdata);
                end
            end
            if (bif.mem_we) mem[bif.mem_addr] = bif.mem_wdata;
            else begin
                rd_pend = 1'b1;
                pend_addr = bif.mem_addr;
                rd_cyc_q.push_back(cyc);
            end
        end
    endtask

    // present a miss, push its expected memory traffic and fill, return one cycle after acceptance
    task automatic issue(input logic [31:0] ma, input logic d, input logic [31:0] va,
                         input logic [LINE_W-1:0] vd, input bit hold);
        logic [31:0] mb, vb;
        req_t r;
        fill_t f;
        int n;
        mb = ma & 32'hFFFF_FFF0;
        vb = va & 32'hFFFF_FFF0;
        if (d) for (int i = 0; i < WORDS; i++) begin
            r.we = 1'b1;
            r.addr = vb + 32'(4 * i);
            r.wdata = vd[32*i +: 32];
            exp_req_q.push_back(r);
            ref_mem[r.addr] = r.wdata;
        end
        f.addr = mb;
        for (int i = 0; i < WORDS; i++) begin
            r.we = 1'b0;
            r.addr = mb + 32'(4 * i);
            r.wdata = 32'h0;
            exp_req_q.push_back(r);
            f.data[32*i +: 32] = ref_rd(r.addr);
        end
        exp_fill_q.push_back(f);
        bif.miss_valid  = 1'b1;
        bif.miss_addr   = ma;
        bif.miss_dirty  = d;
        bif.victim_addr = va;
        bif.victim_data = vd;
        n = 0;
        while (bif.miss_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got miss_ready=%b want 1 within 200 cycles", bif.miss_ready);
        end
        acc_cyc = cyc;
        step();
        if (!hold) begin
            bif.miss_valid  = 1'b0;
            bif.miss_addr   = $urandom;
            bif.miss_dirty  = 1'b1;
            bif.victim_addr = $urandom;
            bif.victim_data = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_fill(input int n0, output bit ok);
        for (int k = 0; k < 300 && fill_cnt <= n0; k++) step();
        ok = fill_cnt > n0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks += 8;
        if (bif.miss_ready !== 1'b1) begin errors++; $display("FAIL rst_miss_ready got %b want 1", bif.miss_ready); end
        if (bif.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", bif.mem_req_valid); end
        if (bif.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", bif.mem_we); end
        if (bif.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", bif.mem_addr); end
        if (bif.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", bif.mem_wdata); end
        if (bif.fill_valid !== 1'b0) begin errors++; $display("FAIL rst_fill_valid got %b want 0", bif.fill_valid); end
        if (bif.fill_addr !== 32'h0) begin errors++; $display("FAIL rst_fill_addr got %h want 0", bif.fill_addr); end
        if (bif.fill_data !== '0) begin errors++; $display("FAIL rst_fill_data got %h want 0", bif.fill_data); end
        rst = 1'b0;
    endtask

    task automatic test_clean_miss();
        int n0, t;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            mem[32'h1230 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
            ref_mem[32'h1230 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
        end
        rd_cyc_q.delete();
        n0 = fill_cnt;
        issue(32'h0000_1234, 1'b0, 32'h0, '0, 1'b0);
        t = acc_cyc;
        wait_fill(n0, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL clean_timeout got fills=%0d want %0d", fill_cnt, n0 + 1); end
        if (fill_cyc - t != 9) begin errors++; $display("FAIL clean_latency got %0d want 9", fill_cyc - t); end
        if (last_fill !== {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000}) begin
            errors++;
            $display("FAIL clean_data got %h want a0000003a0000002a0000001a0000000", last_fill);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_cyc_q.size() != 4 || rd_cyc_q[i] != t + 1 + 2 * i) begin
                errors++;
                $display("FAIL clean_read_slot%0d got %0d want %0d", i, rd_cyc_q.size() > i ? rd_cyc_q[i] - t : -1, 1 + 2 * i);
            end
        end
        step();
        checks++;
        if (bif.miss_ready !== 1'b1 || cyc - t != 10) begin
            errors++;
            $display("FAIL clean_ready_return got ready=%b at +%0d want 1 at +10", bif.miss_ready, cyc - t);
        end
    endtask

    task automatic test_dirty_miss();
        int n0, t;
        bit ok;
        logic [LINE_W-1:0] vd;
        vd = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        rd_cyc_q.delete();
        n0 = fill_cnt;
        issue(32'h0000_4000, 1'b1, 32'h0000_8000, vd, 1'b0);
        t = acc_cyc;
        wait_fill(n0, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL dirty_timeout got fills=%0d want %0d", fill_cnt, n0 + 1); end
        if (fill_cyc - t != 13) begin errors++; $display("FAIL dirty_latency got %0d want 13", fill_cyc - t); end
        if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != t + 5) begin
            errors++;
            $display("FAIL dirty_first_read got +%0d want +5", rd_cyc_q.size() > 0 ? rd_cyc_q[0] - t : -1);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_rd(32'h8000 + 32'(4 * i)) !== 32'hD000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL dirty_wb%0d got %h want %h", i, mem_rd(32'h8000 + 32'(4 * i)), 32'hD000_0000 + 32'(i));
            end
        end
        step();
    endtask

    task automatic test_stall();
        int n0, t;
        bit ok;
        stall_addr = 32'h0000_9004;
        stall_left = 3;
        n0 = fill_cnt;
        issue(32'h0000_5000, 1'b1, 32'h0000_9000, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        t = acc_cyc;
        wait_fill(n0, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL stall_timeout got fills=%0d want %0d", fill_cnt, n0 + 1); end
        if (fill_cyc - t != 16) begin errors++; $display("FAIL stall_latency got %0d want 16", fill_cyc - t); end
        if (stall_left != 0) begin errors++; $display("FAIL stall_consumed got %0d left want 0", stall_left); end
        step();
    endtask

    task automatic test_spurious();
        int n0, t;
        bit ok;
        spur = 1'b1;
        step();
        step();
        checks++;
        if (bif.miss_ready !== 1'b1 || bif.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL spur_idle got ready=%b req=%b want 1 0", bif.miss_ready, bif.mem_req_valid);
        end
        n0 = fill_cnt;
        spur = 1'b1;
        issue(32'h0000_2008, 1'b0, 32'h0, '0, 1'b0);
        t = acc_cyc;
        wait_fill(n0, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL spur_timeout got fills=%0d want %0d", fill_cnt, n0 + 1); end
        if (fill_cyc - t != 9) begin errors++; $display("FAIL spur_latency got %0d want 9", fill_cyc - t); end
        step();
    endtask

    task automatic test_reset_abort();
        int n0, t;
        bit ok;
        issue(32'h0000_3000, 1'b0, 32'h0, '0, 1'b0);
        t = acc_cyc;
        while (cyc < t + 6) step();
        checks++;
        if (bif.mem_req_valid !== 1'b0 || bif.miss_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre got req=%b ready=%b want 0 0", bif.mem_req_valid, bif.miss_ready);
        end
        rst = 1'b1;
        exp_req_q.delete();
        exp_fill_q.delete();
        rd_pend = 1'b0;
        n0 = fill_cnt;
        step();
        checks++;
        if (bif.miss_ready !== 1'b1 || bif.mem_req_valid !== 1'b0 || bif.fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got ready=%b req=%b fill=%b want 1 0 0", bif.miss_ready, bif.mem_req_valid, bif.fill_valid);
        end
        rst = 1'b0;
        repeat (5) step();
        checks++;
        if (fill_cnt != n0) begin errors++; $display("FAIL abort_no_fill got %0d fills want 0", fill_cnt - n0); end
        issue(32'h0000_3000, 1'b0, 32'h0, '0, 1'b0);
        t = acc_cyc;
        wait_fill(n0, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL abort_retry_timeout got fills=%0d want %0d", fill_cnt, n0 + 1); end
        if (fill_cyc - t != 9) begin errors++; $display("FAIL abort_retry_latency got %0d want 9", fill_cyc - t); end
        step();
    endtask

    task automatic test_back_to_back();
        int n0, t1;
        bit ok;
        n0 = fill_cnt;
        issue(32'h0000_6010, 1'b0, 32'h0, '0, 1'b1);
        t1 = acc_cyc;
        issue(32'h0000_7020, 1'b1, 32'h0000_A030, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        checks += 2;
        if (fill_cyc - t1 != 9) begin errors++; $display("FAIL b2b_first_latency got %0d want 9", fill_cyc - t1); end
        if (acc_cyc != fill_cyc + 1) begin errors++; $display("FAIL b2b_accept got +%0d after fill want +1", acc_cyc - fill_cyc); end
        wait_fill(n0 + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout got fills=%0d want %0d", fill_cnt, n0 + 2); end
        step();
    endtask

    task automatic test_random();
        int n0;
        bit ok;
        rnd_ready = 1'b1;
        n0 = fill_cnt;
        issue(32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFE4, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_fill(n0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout got fills=%0d want %0d", fill_cnt, n0 + 1); end
        for (int m = 0; m < 50; m++) begin
            n0 = fill_cnt;
            issue(32'h0001_0000 + 32'($urandom_range(0, 1023)), 1'($urandom_range(1)),
                  32'h0001_0000 + 32'($urandom_range(0, 1023)), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
            wait_fill(n0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_timeout miss=%0d got fills=%0d want %0d", m, fill_cnt, n0 + 1); end
        end
        rnd_ready = 1'b0;
        repeat (3) step();
        checks++;
        if (exp_req_q.size() != 0 || exp_fill_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got req=%0d fill=%0d pending want 0 0", exp_req_q.size(), exp_fill_q.size());
        end
        foreach (ref_mem[k]) begin
            checks++;
            if (mem_rd(k) !== ref_mem[k]) begin
                errors++;
                $display("FAIL mem_store addr=%h got %h want %h", k, mem_rd(k), ref_mem[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bif.miss_valid = 1'b0;
        bif.miss_addr = '0;
        bif.miss_dirty = 1'b0;
        bif.victim_addr = '0;
        bif.victim_data = '0;
        bif.mem_req_ready = 1'b1;
        bif.mem_rvalid = 1'b0;
        bif.mem_rdata = '0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_stall();
        test_spurious();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
